// File: rtl/de_ex_stage_pkg.sv
// Shared definitions for the decode-to-execute stage: datapath width default
// and the forwarding select codes produced by the forwarding unit.
package de_ex_stage_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int FWD_SEL_W    = 2;

    typedef enum logic [FWD_SEL_W-1:0] {
        NOT_FORWARDING  = 2'b00,
        FORWARDING_EX   = 2'b01,
        FORWARDING_MEM  = 2'b10,
        FORWARDING_RSVD = 2'b11
    } fwd_sel_e;

endpackage

// File: rtl/de_ex_stage_operand_mux.sv
// Resolves one source operand from register file, EX result or MEM result.
// Register x0 always reads as zero because the forwarding unit does not filter it.
module de_ex_stage_operand_mux
    import de_ex_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [FWD_SEL_W-1:0] sel,
    input  logic [XLEN-1:0]      rf_data,
    input  logic [XLEN-1:0]      ex_result,
    input  logic [XLEN-1:0]      mem_result,
    input  logic [4:0]           rs,
    output logic [XLEN-1:0]      operand
);

    always_comb begin
        operand = rf_data;
        if (rs == 5'd0) begin
            operand = '0;
        end else begin
            case (fwd_sel_e'(sel))
                FORWARDING_EX:  operand = ex_result;
                FORWARDING_MEM: operand = mem_result;
                default:        operand = rf_data;  // reserved code reads the register file
            endcase
        end
    end

endmodule

// File: rtl/de_ex_stage.sv
// Decode-to-execute pipeline register with operand forwarding and load-use stall.
// Optional macro DE_EX_PERF_EN adds a saturating stall-cycle counter output.
module de_ex_stage
    import de_ex_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 de_valid,
    output logic                 de_ready,
    input  logic [XLEN-1:0]      de_pc,
    input  logic [4:0]           de_rs1,
    input  logic [4:0]           de_rs2,
    input  logic                 de_rs1_used,
    input  logic                 de_rs2_used,
    input  logic [XLEN-1:0]      rf_rdata1,
    input  logic [XLEN-1:0]      rf_rdata2,
    input  logic [4:0]           de_rd,
    input  logic                 de_wen,
    input  logic                 de_is_load,
    input  logic [FWD_SEL_W-1:0] forward_rs1,
    input  logic [FWD_SEL_W-1:0] forward_rs2,
    input  logic [XLEN-1:0]      ex_result,
    input  logic [XLEN-1:0]      mem_result,
    input  logic                 flush,
    input  logic                 ex_ready,
    output logic                 ex_valid,
    output logic [XLEN-1:0]      ex_pc,
    output logic [XLEN-1:0]      ex_op1,
    output logic [XLEN-1:0]      ex_op2,
    output logic [4:0]           ex_rd,
    output logic                 ex_wen,
    output logic                 ex_is_load
`ifdef DE_EX_PERF_EN
    ,
    output logic [31:0]          perf_stall_cycles
`endif
);

    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            hazard;
    logic            rs1_needs_ex;
    logic            rs2_needs_ex;
    logic            ex_wen_q;

    de_ex_stage_operand_mux #(.XLEN(XLEN)) u_mux_rs1 (
        .sel        (forward_rs1),
        .rf_data    (rf_rdata1),
        .ex_result  (ex_result),
        .mem_result (mem_result),
        .rs         (de_rs1),
        .operand    (op1)
    );

    de_ex_stage_operand_mux #(.XLEN(XLEN)) u_mux_rs2 (
        .sel        (forward_rs2),
        .rf_data    (rf_rdata2),
        .ex_result  (ex_result),
        .mem_result (mem_result),
        .rs         (de_rs2),
        .operand    (op2)
    );

    // A load still in EX has no data yet, so an EX forward from it must wait a cycle.
    assign rs1_needs_ex = de_rs1_used && (de_rs1 != 5'd0) && (forward_rs1 == FORWARDING_EX);
    assign rs2_needs_ex = de_rs2_used && (de_rs2 != 5'd0) && (forward_rs2 == FORWARDING_EX);
    assign hazard       = de_valid && ex_valid && ex_is_load && (rs1_needs_ex || rs2_needs_ex);

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends on ready, and a held EX register stays stable.
    assign de_ready = flush || (!hazard && (!ex_valid || ex_ready));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_op1     <= '0;
            ex_op2     <= '0;
            ex_rd      <= '0;
            ex_wen_q   <= 1'b0;
            ex_is_load <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (ex_valid && !ex_ready) begin
            ex_valid <= ex_valid;
        end else if (de_valid && de_ready) begin
            ex_valid   <= 1'b1;
            ex_pc      <= de_pc;
            ex_op1     <= op1;
            ex_op2     <= op2;
            ex_rd      <= de_rd;
            ex_wen_q   <= de_wen;
            ex_is_load <= de_is_load;
        end else begin
            ex_valid <= 1'b0;
        end
    end

    // Bubbles never present a write enable to the forwarding unit.
    assign ex_wen = ex_wen_q && ex_valid;

`ifdef DE_EX_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cycles <= '0;
        end else if (de_valid && hazard && !flush && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_de_ex_stage.sv
// Self-checking bench for de_ex_stage: directed scenarios then random traffic,
// checked against a transaction-level model of the EX register.
module tb_de_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        de_valid;
    logic        de_ready;
    logic [31:0] de_pc;
    logic [4:0]  de_rs1;
    logic [4:0]  de_rs2;
    logic        de_rs1_used;
    logic        de_rs2_used;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [4:0]  de_rd;
    logic        de_wen;
    logic        de_is_load;
    logic [1:0]  forward_rs1;
    logic [1:0]  forward_rs2;
    logic [31:0] ex_result;
    logic [31:0] mem_result;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_op1;
    logic [31:0] ex_op2;
    logic [4:0]  ex_rd;
    logic        ex_wen;
    logic        ex_is_load;
`ifdef DE_EX_PERF_EN
    logic [31:0] perf_stall_cycles;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference view of the instruction sitting in EX.
    typedef struct {
        bit          v;
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        bit          wen;
        bit          ld;
    } ex_slot_t;

    ex_slot_t    m;
    logic [31:0] m_stalls;

    de_ex_stage dut (
        .clk         (clk),
        .reset       (reset),
        .de_valid    (de_valid),
        .de_ready    (de_ready),
        .de_pc       (de_pc),
        .de_rs1      (de_rs1),
        .de_rs2      (de_rs2),
        .de_rs1_used (de_rs1_used),
        .de_rs2_used (de_rs2_used),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .de_rd       (de_rd),
        .de_wen      (de_wen),
        .de_is_load  (de_is_load),
        .forward_rs1 (forward_rs1),
        .forward_rs2 (forward_rs2),
        .ex_result   (ex_result),
        .mem_result  (mem_result),
        .flush       (flush),
        .ex_ready    (ex_ready),
        .ex_valid    (ex_valid),
        .ex_pc       (ex_pc),
        .ex_op1      (ex_op1),
        .ex_op2      (ex_op2),
        .ex_rd       (ex_rd),
        .ex_wen      (ex_wen),
        .ex_is_load  (ex_is_load)
`ifdef DE_EX_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // model helpers
    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [4:0] rs,
                                         input logic [31:0] rf);
        if (rs == 5'd0) return 32'd0;
        if (sel == 2'b01) return ex_result;
        if (sel == 2'b10) return mem_result;
        return rf;
    endfunction

    function automatic bit model_hazard();
        bit need1 = de_rs1_used && de_rs1 != 5'd0 && forward_rs1 == 2'b01;
        bit need2 = de_rs2_used && de_rs2 != 5'd0 && forward_rs2 == 2'b01;
        return de_valid && m.v && m.ld && (need1 || need2);
    endfunction

    function automatic bit model_ready();
        return flush || (!model_hazard() && (!m.v || ex_ready));
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, m.v});
        chk({tag, ".ex_wen"}, {31'd0, ex_wen}, {31'd0, m.v && m.wen});
        if (m.v) begin
            chk({tag, ".ex_pc"}, ex_pc, m.pc);
            chk({tag, ".ex_op1"}, ex_op1, m.op1);
            chk({tag, ".ex_op2"}, ex_op2, m.op2);
            chk({tag, ".ex_rd"}, {27'd0, ex_rd}, {27'd0, m.rd});
            chk({tag, ".ex_is_load"}, {31'd0, ex_is_load}, {31'd0, m.ld});
        end
`ifdef DE_EX_PERF_EN
        chk({tag, ".perf"}, perf_stall_cycles, m_stalls);
`endif
    endtask

    task automatic model_reset();
        m = '{v: 1'b0, pc: '0, op1: '0, op2: '0, rd: '0, wen: 1'b0, ld: 1'b0};
        m_stalls = '0;
    endtask

    // driver: inputs are set after a falling edge; one call = one clock cycle
    task automatic step(input string tag);
        ex_slot_t nxt;
        bit rdy;
        #1;
        rdy = model_ready();
        chk({tag, ".de_ready"}, {31'd0, de_ready}, {31'd0, rdy});
        nxt = m;
        if (flush) nxt.v = 1'b0;
        else if (m.v && !ex_ready) nxt = m;
        else if (de_valid && rdy) begin
            nxt.v   = 1'b1;
            nxt.pc  = de_pc;
            nxt.op1 = pick(forward_rs1, de_rs1, rf_rdata1);
            nxt.op2 = pick(forward_rs2, de_rs2, rf_rdata2);
            nxt.rd  = de_rd;
            nxt.wen = de_wen;
            nxt.ld  = de_is_load;
        end else nxt.v = 1'b0;
        if (de_valid && model_hazard() && !flush && m_stalls != 32'hFFFF_FFFF) m_stalls++;
        @(posedge clk);
        #1;
        m = nxt;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic idle();
        de_valid = 0; de_pc = '0; de_rs1 = '0; de_rs2 = '0;
        de_rs1_used = 0; de_rs2_used = 0; rf_rdata1 = '0; rf_rdata2 = '0;
        de_rd = '0; de_wen = 0; de_is_load = 0; forward_rs1 = 2'b00; forward_rs2 = 2'b00;
        ex_result = '0; mem_result = '0; flush = 0; ex_ready = 1;
    endtask

    task automatic instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input bit ld);
        de_valid = 1; de_pc = pc; de_rs1 = rs1; de_rs2 = rs2;
        de_rs1_used = 1; de_rs2_used = 1; de_rd = rd; de_wen = 1; de_is_load = ld;
        forward_rs1 = 2'b00; forward_rs2 = 2'b00;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_outputs("reset");
        chk("reset.ex_pc", ex_pc, 32'd0);
        chk("reset.ex_op1", ex_op1, 32'd0);
        chk("reset.ex_rd", {27'd0, ex_rd}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // addi x1 = 5, then add x2, x1, x1 with EX forwarding
        instr(32'h100, 5'd0, 5'd0, 5'd1, 0); de_rs2_used = 0;
        step("addi");
        instr(32'h104, 5'd1, 5'd1, 5'd2, 0);
        forward_rs1 = 2'b01; forward_rs2 = 2'b01; ex_result = 32'd5; rf_rdata1 = 32'hAAAA;
        step("add_fwd_ex");
        chk("add.op1", ex_op1, 32'd5);
        chk("add.op2", ex_op2, 32'd5);

        // MEM forwarding on rs2
        instr(32'h108, 5'd6, 5'd4, 5'd7, 0);
        forward_rs2 = 2'b10; mem_result = 32'hDEADBEEF; rf_rdata2 = 32'd0; rf_rdata1 = 32'h11;
        step("fwd_mem");
        chk("fwd_mem.op2", ex_op2, 32'hDEADBEEF);

        // reserved select behaves as register-file read
        instr(32'h10C, 5'd5, 5'd6, 5'd8, 0);
        forward_rs1 = 2'b11; rf_rdata1 = 32'h5555; ex_result = 32'h1; mem_result = 32'h2;
        step("fwd_rsvd");
        chk("fwd_rsvd.op1", ex_op1, 32'h5555);

        // load-use: lw x3 then consumer of x3
        instr(32'h110, 5'd2, 5'd0, 5'd3, 1); de_rs2_used = 0;
        step("load");
        instr(32'h114, 5'd3, 5'd9, 5'd4, 0);
        forward_rs1 = 2'b01; ex_result = 32'hBAD;
        #1;
        chk("loaduse.stall_ready", {31'd0, de_ready}, 32'd0);
        step("loaduse_stall");
        chk("loaduse.bubble", {31'd0, ex_valid}, 32'd0);
        forward_rs1 = 2'b10; mem_result = 32'd7;
        step("loaduse_accept");
        chk("loaduse.op1", ex_op1, 32'd7);

        // x0 never forwards and never stalls, even behind a load
        instr(32'h118, 5'd2, 5'd0, 5'd5, 1); de_rs2_used = 0;
        step("load2");
        instr(32'h11C, 5'd0, 5'd0, 5'd6, 0);
        forward_rs1 = 2'b01; forward_rs2 = 2'b01; ex_result = 32'h1234;
        step("x0");
        chk("x0.op1", ex_op1, 32'd0);

        // four back-to-back load-use stalls
        for (int i = 0; i < 4; i++) begin
            instr(32'h200 + 32'(i * 8), 5'd1, 5'd0, 5'd10, 1); de_rs2_used = 0;
            step("perf_load");
            instr(32'h204 + 32'(i * 8), 5'd0, 5'd10, 5'd11, 0);
            forward_rs2 = 2'b01;
            step("perf_stall");
            forward_rs2 = 2'b10; mem_result = 32'(i);
            step("perf_accept");
        end

        // back-pressure: EX stalls for three cycles
        instr(32'h300, 5'd1, 5'd2, 5'd12, 0); rf_rdata1 = 32'h77; rf_rdata2 = 32'h88;
        step("bp_load");
        ex_ready = 0;
        for (int i = 0; i < 3; i++) begin
            instr(32'h304 + 32'(i * 4), 5'd3, 5'd4, 5'd13, 0);
            rf_rdata1 = $urandom; rf_rdata2 = $urandom;
            step("bp_hold");
            chk("bp_hold.pc", ex_pc, 32'h300);
        end
        // flush while held with a valid incoming instruction
        flush = 1;
        step("flush");
        chk("flush.valid", {31'd0, ex_valid}, 32'd0);
        flush = 0; ex_ready = 1;

        // reset arriving mid-hold takes effect without a clock edge
        instr(32'h400, 5'd1, 5'd2, 5'd14, 1);
        step("rst_load");
        ex_ready = 0;
        step("rst_hold");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_reset.valid", {31'd0, ex_valid}, 32'd0);
        check_outputs("async_reset");
        @(negedge clk);
        reset = 1'b0;
        idle();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            de_valid    = ($urandom_range(0, 3) != 0);
            de_pc       = $urandom;
            de_rs1      = 5'($urandom_range(0, 3));
            de_rs2      = 5'($urandom_range(0, 3));
            de_rs1_used = $urandom_range(0, 1) != 0;
            de_rs2_used = $urandom_range(0, 1) != 0;
            rf_rdata1   = $urandom;
            rf_rdata2   = $urandom;
            de_rd       = 5'($urandom_range(0, 31));
            de_wen      = $urandom_range(0, 1) != 0;
            de_is_load  = $urandom_range(0, 2) == 0;
            forward_rs1 = 2'($urandom_range(0, 3));
            forward_rs2 = 2'($urandom_range(0, 3));
            ex_result   = $urandom;
            mem_result  = $urandom;
            flush       = $urandom_range(0, 15) == 0;
            ex_ready    = $urandom_range(0, 3) != 0;
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/de_ex_stage.md
Name: de_ex_stage

Overview:
- Decode-to-execute pipeline register; sits directly downstream of the forwarding unit and consumes its per-operand select codes.
- Each cycle it picks each source operand from one of three places: the register-file read data, the EX-stage result, or the MEM-stage result.
- It detects load-use hazards the forwarding unit cannot resolve, then stalls decode and inserts a bubble.
- It registers the operands plus control into EX under a valid/ready handshake, with flush support.

Parameters:
XLEN, 32, datapath width of operands, results and PC

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
de_valid  input  1  decode holds an instruction
de_ready  output  1  this stage accepts the decode instruction this cycle
de_pc  input  XLEN  decode PC
de_rs1  input  5  source register 1 index
de_rs2  input  5  source register 2 index
de_rs1_used  input  1  instruction reads rs1
de_rs2_used  input  1  instruction reads rs2
rf_rdata1  input  XLEN  register file read data, port 1
rf_rdata2  input  XLEN  register file read data, port 2
de_rd  input  5  destination register
de_wen  input  1  instruction writes rd
de_is_load  input  1  instruction is a load
forward_rs1  input  2  forwarding select for rs1
forward_rs2  input  2  forwarding select for rs2
ex_result  input  XLEN  result of the instruction currently in EX
mem_result  input  XLEN  result or load data in MEM
flush  input  1  discard the EX-register contents and the incoming instruction
ex_ready  input  1  EX accepts ex_* this cycle
ex_valid  output  1  EX register holds a valid instruction
ex_pc  output  XLEN  registered PC
ex_op1  output  XLEN  registered resolved operand 1
ex_op2  output  XLEN  registered resolved operand 2
ex_rd  output  5  registered rd (also feeds the forwarding unit)
ex_wen  output  1  registered write enable, qualified by ex_valid
ex_is_load  output  1  registered load flag

Behaviour:
- Reset (asynchronous): every registered output is cleared to 0; ex_valid=0.
- Select decode:
  - NOT_FORWARDING=2'b00 selects rf_rdata.
  - FORWARDING_EX=2'b01 selects ex_result.
  - FORWARDING_MEM=2'b10 selects mem_result.
  - 2'b11 is reserved and behaves as 2'b00.
- x0 rule: if rsN==0, opN=0 regardless of select. The forwarding unit does not filter x0, so this stage must.
- Load-use hazard (combinational): de_valid & ex_valid & ex_is_load & ((de_rs1_used & rs1!=0 & forward_rs1==EX) | (same for rs2)).
- de_ready = flush | (!hazard & (!ex_valid | ex_ready)).
- Next-state priority, highest first:
  1. flush: ex_valid<=0; incoming instruction dropped.
  2. ex_valid & !ex_ready: hold; all ex_* outputs stable.
  3. de_valid & de_ready: load the resolved operands and control; ex_valid<=1.
  4. Otherwise, including a hazard: ex_valid<=0 (bubble). Other fields may be left unchanged.
- Latency: 1 cycle from decode acceptance to ex_valid.
- A hazard lasts exactly one cycle when EX is ready. Next cycle the load sits in MEM, the select becomes MEM, and the instruction is accepted.
- ex_wen is only meaningful when ex_valid=1. A bubble forces ex_wen=0 so the forwarding unit never matches on it.
- Reset mid-operation: the in-flight instruction is lost; no partial outputs.

Optional Feature:
- Macro: DE_EX_PERF_EN.
- When defined:
  - Adds output perf_stall_cycles (32 bits).
  - Counts cycles with de_valid & hazard & !flush.
  - Saturates at 0xFFFFFFFF.
  - Cleared by reset.
- When undefined: the port and the counter are absent; behaviour is otherwise identical.

Decomposition:
- NOT_FORWARDING, FORWARDING_EX and FORWARDING_MEM stay in the shared defines include, as does the 2-bit select width.
- XLEN default also lives in the shared defines.
- One natural sub-module, operand_mux: select, rf data, ex_result, mem_result and the rs index in; resolved operand out. It is instantiated twice.

Test Plan:
- Sequence `addi x1=5` then `add x2,x1,x1`:
  - rs1=rs2=1, forward=01, ex_result=5 → next cycle ex_op1=ex_op2=5, ex_valid=1, no stall.
- MEM forward: forward_rs2=10, mem_result=0xDEADBEEF, rf_rdata2=0 → ex_op2=0xDEADBEEF.
- Load-use:
  - Setup: ex_is_load=1, ex_valid=1, forward_rs1=01, rs1=3, ex_ready=1.
  - Stall cycle: de_ready=0, then ex_valid=0 (bubble).
  - Next cycle: forward=10, mem_result=7 → accepted, ex_op1=7.
- x0: rs1=0, forward_rs1=01, ex_result=0x1234 → ex_op1=0; no hazard even with ex_is_load=1.
- Back-pressure and flush:
  - ex_ready=0 for 3 cycles → ex_* stable and de_ready=0.
  - flush with de_valid=1 → ex_valid=0 next cycle and de_ready=1.
  - reset asserted mid-hold → ex_valid=0 immediately, without waiting for a clock edge.
- With DE_EX_PERF_EN: 4 load-use stalls → perf_stall_cycles=4; a preload of 0xFFFFFFFF stays saturated.
